// File: rtl/mux4_rr_pkg.sv
// Shared constants and FSM state type for the 4-way round-robin MUX select generator.
package mux4_rr_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set req bit scanning ptr, ptr+1, ... mod 4. Purely combinational.
// No backpressure; any=0 when no request is pending (idx is then 0).
module rr_pick4
  import mux4_rr_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] pos;
  logic             found;

  always_comb begin
    idx   = '0;
    pos   = '0;
    found = 1'b0;
    any   = |req;
    for (int k = 0; k < N_CH; k++) begin
      // 2-bit arithmetic wraps naturally past source 3
      pos = ptr + SEL_W'(k);
      if (!found && req[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_sel.sv
// Round-robin select for a 4:1 MUX: grant 1 cycle after request, c held for the whole grant, one idle cycle after release.
// Holder releases via done or by dropping req; MUX4_RR_SEL_TIMEOUT_EN adds forced release after TIMEOUT cycles.
module mux4_rr_sel
  import mux4_rr_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic             done,
  output logic [SEL_W-1:0] c,
  output logic [N_CH-1:0]  gnt,
  output logic             busy,
  output logic             timeout
);

  if (TIMEOUT < 2 || TIMEOUT > (1 << CNT_W) - 1) begin : g_bad_timeout
    $error("TIMEOUT must lie in 2..2^CNT_W-1");
  end

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [SEL_W-1:0] c_nxt;
  logic [N_CH-1:0]  gnt_nxt;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             rel_norm;
  logic             hold_expired;
  logic             release_now;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign rel_norm    = done || !req[c];
  assign release_now = (state == GRANT) && (rel_norm || hold_expired);
  assign busy        = (state == GRANT);

`ifdef MUX4_RR_SEL_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;

  assign hold_expired = (state == GRANT) && (cnt == CNT_W'(TIMEOUT - 1));

  // Counter sits at 0 throughout IDLE, so it is already clear on entry to GRANT
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= (state == GRANT && !release_now) ? cnt + CNT_W'(1) : '0;
      timeout <= release_now && !rel_norm;
    end
  end
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    c_nxt     = c;
    gnt_nxt   = gnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          c_nxt     = pick_idx;
          gnt_nxt   = N_CH'(1) << pick_idx;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          gnt_nxt   = '0;
          ptr_nxt   = c + SEL_W'(1);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      c     <= '0;
      gnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      c     <= c_nxt;
      gnt   <= gnt_nxt;
    end
  end

endmodule

// File: tb/tb_mux4_rr_sel.sv
// Directed scoreboard bench for mux4_rr_sel; expected outputs per cycle are queued at drive time.
module tb_mux4_rr_sel;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] c;
  logic [3:0] gnt;
  logic       busy;
  logic       timeout;

  typedef struct {
    string      tag;
    logic [1:0] c;
    logic [3:0] gnt;
    logic       busy;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  mux4_rr_sel #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .c       (c),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  // Drive one cycle of stimulus, queue the outputs expected after the edge, then score them.
  task automatic step(input string tag, input logic r, input logic [3:0] rq, input logic d,
                      input logic [1:0] ec, input logic [3:0] eg, input logic eb, input logic et);
    exp_t e;
    @(negedge clk);
    rst  = r;
    req  = rq;
    done = d;
    e.tag = tag; e.c = ec; e.gnt = eg; e.busy = eb; e.to = et;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({e.tag, "_c"},       32'(c),       32'(e.c));
      check({e.tag, "_gnt"},     32'(gnt),     32'(e.gnt));
      check({e.tag, "_busy"},    32'(busy),    32'(e.busy));
      check({e.tag, "_timeout"}, 32'(timeout), 32'(e.to));
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; done = 1'b0;

    step("reset",        1, 4'b0000, 0, 2'd0, 4'b0000, 0, 0);
    step("single_gnt",   0, 4'b0100, 0, 2'd2, 4'b0100, 1, 0);
    step("single_rel",   0, 4'b0100, 1, 2'd2, 4'b0000, 0, 0);
    // ptr is now 3
    step("wrap_gnt3",    0, 4'b1001, 0, 2'd3, 4'b1000, 1, 0);
    step("wrap_rel3",    0, 4'b1001, 1, 2'd3, 4'b0000, 0, 0);
    step("wrap_gnt0",    0, 4'b1001, 0, 2'd0, 4'b0001, 1, 0);
    step("wrap_rel0",    0, 4'b1001, 1, 2'd0, 4'b0000, 0, 0);
    // fairness with all requesting, starting from ptr=1
    step("fair_g1",      0, 4'b1111, 0, 2'd1, 4'b0010, 1, 0);
    step("fair_r1",      0, 4'b1111, 1, 2'd1, 4'b0000, 0, 0);
    step("fair_g2",      0, 4'b1111, 0, 2'd2, 4'b0100, 1, 0);
    step("fair_r2",      0, 4'b1111, 1, 2'd2, 4'b0000, 0, 0);
    step("fair_g3",      0, 4'b1111, 0, 2'd3, 4'b1000, 1, 0);
    step("fair_r3",      0, 4'b1111, 1, 2'd3, 4'b0000, 0, 0);
    step("fair_g0",      0, 4'b1111, 0, 2'd0, 4'b0001, 1, 0);
    step("fair_r0",      0, 4'b1111, 1, 2'd0, 4'b0000, 0, 0);
    // withdrawal of source 1; other bits toggling must not disturb the grant
    step("wd_gnt1",      0, 4'b0010, 0, 2'd1, 4'b0010, 1, 0);
    step("wd_other",     0, 4'b0111, 0, 2'd1, 4'b0010, 1, 0);
    step("wd_drop",      0, 4'b1100, 0, 2'd1, 4'b0000, 0, 0);
    step("wd_next3",     0, 4'b1001, 0, 2'd3, 4'b1000, 1, 0);
    step("wd_rel3",      0, 4'b1001, 1, 2'd3, 4'b0000, 0, 0);
    step("idle_done",    0, 4'b0000, 1, 2'd3, 4'b0000, 0, 0);
    step("idle_quiet",   0, 4'b0000, 0, 2'd3, 4'b0000, 0, 0);
    // reset in the middle of a grant
    step("rst_gnt2",     0, 4'b0100, 0, 2'd2, 4'b0100, 1, 0);
    step("rst_mid",      1, 4'b0100, 0, 2'd0, 4'b0000, 0, 0);
    step("rst_after",    0, 4'b1111, 0, 2'd0, 4'b0001, 1, 0);
    step("rst_rel",      0, 4'b1111, 1, 2'd0, 4'b0000, 0, 0);
    // source 1 holds with no done
    step("to_gnt",       0, 4'b0010, 0, 2'd1, 4'b0010, 1, 0);
`ifdef MUX4_RR_SEL_TIMEOUT_EN
    for (int i = 0; i < 3; i++)
      step($sformatf("to_hold%0d", i), 0, 4'b0010, 0, 2'd1, 4'b0010, 1, 0);
    step("to_fire",      0, 4'b0010, 0, 2'd1, 4'b0000, 0, 1);
    step("to_pulse_end", 0, 4'b0000, 0, 2'd1, 4'b0000, 0, 0);
    // done coincides with the expiry cycle: plain release, no pulse
    step("sim_gnt",      0, 4'b0010, 0, 2'd1, 4'b0010, 1, 0);
    for (int i = 0; i < 3; i++)
      step($sformatf("sim_hold%0d", i), 0, 4'b0010, 0, 2'd1, 4'b0010, 1, 0);
    step("sim_rel",      0, 4'b0010, 1, 2'd1, 4'b0000, 0, 0);
    step("sim_after",    0, 4'b0000, 0, 2'd1, 4'b0000, 0, 0);
`else
    for (int i = 0; i < 22; i++)
      step($sformatf("nto_hold%0d", i), 0, 4'b0010, 0, 2'd1, 4'b0010, 1, 0);
    step("nto_rel",      0, 4'b0010, 1, 2'd1, 4'b0000, 0, 0);
    step("nto_after",    0, 4'b0000, 0, 2'd1, 4'b0000, 0, 0);
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
